// File: rtl/aux_reply_decoder_mb.sv
// Purpose : parses one AUX reply burst (header byte, then data bytes) from the BDI,
//           decodes mode/ACK, streams data with an index and checks burst length.
// Latency : 1 clk from an input byte to every output; no backpressure (BDI cannot stall).
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   bdi_aux_in / _vld            reply byte stream; vld high for the whole burst
//   aux_ctrl_i2c_native          mode (0 native, 1 I2C-over-AUX), sampled on header
//   aux_ctrl_exp_len             expected data-byte count, sampled on header
//   reply_ack / reply_ack_vld    decoded ACK field, pulse when the header is decoded
//   reply_hdr_err                header low nibble nonzero (only with the option below)
//   reply_dec_i2c_native         latched mode, held for the reply
//   reply_data / _vld / _idx     forwarded data byte, its strobe and 0-based index
//   reply_done                   end-of-reply pulse; reply_byte_cnt / reply_len_err valid with it
//   reply_ovf                    sticky: bytes beyond MAX_BYTES were dropped
//
// Optional build macro AUX_REPLY_DEC_HDR_CHK_EN: require header bits [3:0] == 0; a
// violating reply raises reply_hdr_err and has all of its data bytes suppressed.
module aux_reply_decoder_mb #(
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bdi_aux_in,
  input  logic              bdi_aux_in_vld,
  input  logic              aux_ctrl_i2c_native,
  input  logic [CNT_W-1:0]  aux_ctrl_exp_len,
  output logic [1:0]        reply_ack,
  output logic              reply_ack_vld,
`ifdef AUX_REPLY_DEC_HDR_CHK_EN
  output logic              reply_hdr_err,
`endif
  output logic              reply_dec_i2c_native,
  output logic [DATA_W-1:0] reply_data,
  output logic              reply_data_vld,
  output logic [CNT_W-1:0]  reply_data_idx,
  output logic              reply_done,
  output logic [CNT_W-1:0]  reply_byte_cnt,
  output logic              reply_len_err,
  output logic              reply_ovf
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        ack_q, ack_d;
  logic              ack_vld_q, ack_vld_d;
  logic              i2c_q, i2c_d;
  logic [CNT_W-1:0]  exp_len_q, exp_len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              data_vld_q, data_vld_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic              len_err_q, len_err_d;
  logic              ovf_q, ovf_d;
  logic              hdr_take;

`ifdef AUX_REPLY_DEC_HDR_CHK_EN
  logic hdr_bad_q, hdr_bad_d;
  logic hdr_err_q, hdr_err_d;
`else
  // Without header checking no reply is ever marked bad.
  logic hdr_bad_q;
  assign hdr_bad_q = 1'b0;
`endif

  // A header can be taken in IDLE or in the DONE cycle (back-to-back replies).
  assign hdr_take = bdi_aux_in_vld && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d    = state_q;
    ack_d      = ack_q;
    ack_vld_d  = 1'b0;
    i2c_d      = i2c_q;
    exp_len_d  = exp_len_q;
    cnt_d      = cnt_q;
    data_d     = '0;
    data_vld_d = 1'b0;
    idx_d      = '0;
    done_d     = 1'b0;
    byte_cnt_d = '0;
    len_err_d  = 1'b0;
    ovf_d      = ovf_q;
`ifdef AUX_REPLY_DEC_HDR_CHK_EN
    hdr_bad_d  = hdr_bad_q;
    hdr_err_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // Header handling is shared with DONE below.
      end

      DATA: begin
        if (bdi_aux_in_vld) begin
          if (hdr_bad_q) begin
            // Reply with a malformed header: swallow its data entirely.
          end else if (cnt_q < MAX_CNT) begin
            data_d     = bdi_aux_in;
            data_vld_d = 1'b1;
            idx_d      = cnt_q;
            cnt_d      = cnt_q + ONE;
          end else begin
            // Count saturates at MAX_BYTES, which keeps ovf => byte_cnt == MAX_BYTES.
            ovf_d = 1'b1;
          end
        end else begin
          state_d    = DONE;
          done_d     = 1'b1;
          byte_cnt_d = cnt_q;
          // Only an ACKed reply has a meaningful length to check.
          len_err_d  = (ack_q == 2'b00) && !hdr_bad_q && (cnt_q != exp_len_q);
        end
      end

      DONE: begin
        state_d = IDLE;
        ack_d   = 2'b00;
        i2c_d   = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A new header overrides the clearing done on leaving DONE.
    if (hdr_take) begin
      state_d   = DATA;
      ack_d     = aux_ctrl_i2c_native ? bdi_aux_in[7:6] : bdi_aux_in[5:4];
      ack_vld_d = 1'b1;
      i2c_d     = aux_ctrl_i2c_native;
      exp_len_d = aux_ctrl_exp_len;
      cnt_d     = '0;
      ovf_d     = 1'b0;
`ifdef AUX_REPLY_DEC_HDR_CHK_EN
      hdr_bad_d = |bdi_aux_in[3:0];
      hdr_err_d = |bdi_aux_in[3:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q      <= 2'b00;
      ack_vld_q  <= 1'b0;
      i2c_q      <= 1'b0;
      exp_len_q  <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      data_vld_q <= 1'b0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      byte_cnt_q <= '0;
      len_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef AUX_REPLY_DEC_HDR_CHK_EN
      hdr_bad_q  <= 1'b0;
      hdr_err_q  <= 1'b0;
`endif
    end else begin
      ack_q      <= ack_d;
      ack_vld_q  <= ack_vld_d;
      i2c_q      <= i2c_d;
      exp_len_q  <= exp_len_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      data_vld_q <= data_vld_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      byte_cnt_q <= byte_cnt_d;
      len_err_q  <= len_err_d;
      ovf_q      <= ovf_d;
`ifdef AUX_REPLY_DEC_HDR_CHK_EN
      hdr_bad_q  <= hdr_bad_d;
      hdr_err_q  <= hdr_err_d;
`endif
    end
  end

  assign reply_ack            = ack_q;
  assign reply_ack_vld        = ack_vld_q;
  assign reply_dec_i2c_native = i2c_q;
  assign reply_data           = data_q;
  assign reply_data_vld       = data_vld_q;
  assign reply_data_idx       = idx_q;
  assign reply_done           = done_q;
  assign reply_byte_cnt       = byte_cnt_q;
  assign reply_len_err        = len_err_q;
  assign reply_ovf            = ovf_q;
`ifdef AUX_REPLY_DEC_HDR_CHK_EN
  assign reply_hdr_err        = hdr_err_q;
`endif

endmodule

// File: tb/tb_aux_reply_decoder_mb.sv
// Bench for aux_reply_decoder_mb: directed replies from the test plan followed by
// random bursts, each checked cycle by cycle against a reply-level reference model.
module tb_aux_reply_decoder_mb;

  localparam int DATA_W    = 8;
  localparam int MAX_BYTES = 16;
  localparam int CNT_W     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] bdi_aux_in = '0;
  logic              bdi_aux_in_vld = 1'b0;
  logic              aux_ctrl_i2c_native = 1'b0;
  logic [CNT_W-1:0]  aux_ctrl_exp_len = '0;
  logic [1:0]        reply_ack;
  logic              reply_ack_vld;
  logic              reply_dec_i2c_native;
  logic [DATA_W-1:0] reply_data;
  logic              reply_data_vld;
  logic [CNT_W-1:0]  reply_data_idx;
  logic              reply_done;
  logic [CNT_W-1:0]  reply_byte_cnt;
  logic              reply_len_err;
  logic              reply_ovf;
`ifdef AUX_REPLY_DEC_HDR_CHK_EN
  logic              reply_hdr_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] dat [0:31];

  always #5 clk = ~clk;

  aux_reply_decoder_mb #(
    .DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .bdi_aux_in          (bdi_aux_in),
    .bdi_aux_in_vld      (bdi_aux_in_vld),
    .aux_ctrl_i2c_native (aux_ctrl_i2c_native),
    .aux_ctrl_exp_len    (aux_ctrl_exp_len),
    .reply_ack           (reply_ack),
    .reply_ack_vld       (reply_ack_vld),
`ifdef AUX_REPLY_DEC_HDR_CHK_EN
    .reply_hdr_err       (reply_hdr_err),
`endif
    .reply_dec_i2c_native(reply_dec_i2c_native),
    .reply_data          (reply_data),
    .reply_data_vld      (reply_data_vld),
    .reply_data_idx      (reply_data_idx),
    .reply_done          (reply_done),
    .reply_byte_cnt      (reply_byte_cnt),
    .reply_len_err       (reply_len_err),
    .reply_ovf           (reply_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ack"},      32'(reply_ack), 32'd0);
    check({tag, ".ack_vld"},  32'(reply_ack_vld), 32'd0);
    check({tag, ".i2c"},      32'(reply_dec_i2c_native), 32'd0);
    check({tag, ".data"},     32'(reply_data), 32'd0);
    check({tag, ".data_vld"}, 32'(reply_data_vld), 32'd0);
    check({tag, ".idx"},      32'(reply_data_idx), 32'd0);
    check({tag, ".done"},     32'(reply_done), 32'd0);
    check({tag, ".byte_cnt"}, 32'(reply_byte_cnt), 32'd0);
    check({tag, ".len_err"},  32'(reply_len_err), 32'd0);
    check({tag, ".ovf"},      32'(reply_ovf), 32'd0);
  endtask

  // Drives one reply (header + n bytes from dat[]) and checks every output cycle.
  // The model works at reply level: which bytes get through, final count, flags.
  // With idle_after=0 the task returns in the DONE cycle so the caller can chain
  // the next header straight into it.
  task automatic run_burst(input string tag, input logic [7:0] hdr, input logic mode,
                           input logic [4:0] exp, input int n, input bit idle_after);
    logic [1:0] eack;
    bit bad;
    int fwd;
    bit eovf;
    eack = mode ? hdr[7:6] : hdr[5:4];
    bad  = 1'b0;
`ifdef AUX_REPLY_DEC_HDR_CHK_EN
    bad  = (hdr[3:0] != 4'h0);
`endif
    fwd  = bad ? 0 : ((n > MAX_BYTES) ? MAX_BYTES : n);
    eovf = !bad && (n > MAX_BYTES);

    bdi_aux_in_vld = 1'b1;
    bdi_aux_in = hdr;
    aux_ctrl_i2c_native = mode;
    aux_ctrl_exp_len = exp;
    tick();
    check({tag, ".hdr.ack_vld"}, 32'(reply_ack_vld), 32'd1);
    check({tag, ".hdr.ack"}, 32'(reply_ack), 32'(eack));
    check({tag, ".hdr.i2c"}, 32'(reply_dec_i2c_native), 32'(mode));
    check({tag, ".hdr.data_vld"}, 32'(reply_data_vld), 32'd0);
    check({tag, ".hdr.done"}, 32'(reply_done), 32'd0);
    check({tag, ".hdr.ovf"}, 32'(reply_ovf), 32'd0);
`ifdef AUX_REPLY_DEC_HDR_CHK_EN
    check({tag, ".hdr.hdr_err"}, 32'(reply_hdr_err), 32'(bad));
`endif
    // Mode and expected length must only matter on the header byte.
    aux_ctrl_i2c_native = ~mode;
    aux_ctrl_exp_len = 5'($urandom);

    for (int i = 0; i < n; i++) begin
      bdi_aux_in = dat[i];
      tick();
      check({tag, ".dat.ack_vld"}, 32'(reply_ack_vld), 32'd0);
      check({tag, ".dat.ack"}, 32'(reply_ack), 32'(eack));
      check({tag, ".dat.i2c"}, 32'(reply_dec_i2c_native), 32'(mode));
      if (i < fwd) begin
        check({tag, ".dat.vld"}, 32'(reply_data_vld), 32'd1);
        check({tag, ".dat.byte"}, 32'(reply_data), 32'(dat[i]));
        check({tag, ".dat.idx"}, 32'(reply_data_idx), 32'(i));
      end else begin
        check({tag, ".drop.vld"}, 32'(reply_data_vld), 32'd0);
        check({tag, ".drop.byte"}, 32'(reply_data), 32'd0);
        check({tag, ".drop.idx"}, 32'(reply_data_idx), 32'd0);
        check({tag, ".drop.ovf"}, 32'(reply_ovf), 32'(!bad));
      end
    end

    bdi_aux_in_vld = 1'b0;
    bdi_aux_in = 8'($urandom);
    tick();
    check({tag, ".done"}, 32'(reply_done), 32'd1);
    check({tag, ".done.byte_cnt"}, 32'(reply_byte_cnt), 32'(fwd));
    check({tag, ".done.len_err"}, 32'(reply_len_err),
          32'((eack == 2'b00) && !bad && (fwd != int'(exp))));
    check({tag, ".done.ovf"}, 32'(reply_ovf), 32'(eovf));
    check({tag, ".done.ack"}, 32'(reply_ack), 32'(eack));
    check({tag, ".done.i2c"}, 32'(reply_dec_i2c_native), 32'(mode));
    check({tag, ".done.data_vld"}, 32'(reply_data_vld), 32'd0);

    if (idle_after) begin
      tick();
      check({tag, ".idle.done"}, 32'(reply_done), 32'd0);
      check({tag, ".idle.ack"}, 32'(reply_ack), 32'd0);
      check({tag, ".idle.i2c"}, 32'(reply_dec_i2c_native), 32'd0);
      check({tag, ".idle.ack_vld"}, 32'(reply_ack_vld), 32'd0);
      check({tag, ".idle.byte_cnt"}, 32'(reply_byte_cnt), 32'd0);
      check({tag, ".idle.ovf"}, 32'(reply_ovf), 32'(eovf));
    end
  endtask

  initial begin
    logic [7:0] hdr;
    int n;

    // Reset state
    #2;
    check_all_zero("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check_all_zero("post_rst");

    // Native ACK, four bytes, length matches
    dat[0] = 8'hAA; dat[1] = 8'hBB; dat[2] = 8'hCC; dat[3] = 8'hDD;
    run_burst("native4", 8'h00, 1'b0, 5'd4, 4, 1'b1);

    // I2C NACK, header only
    run_burst("i2c_nack", 8'h40, 1'b1, 5'd0, 0, 1'b1);

    // Overflow: 18 bytes against a 16-byte cap
    for (int i = 0; i < 18; i++) dat[i] = 8'(i + 1);
    run_burst("ovf18", 8'h00, 1'b0, 5'd16, 18, 1'b1);

    // DEFER, then a new header arriving in the DONE cycle
    run_burst("defer", 8'h20, 1'b0, 5'd2, 0, 1'b0);
    dat[0] = 8'h5A;
    run_burst("chained", 8'h00, 1'b0, 5'd1, 1, 1'b1);

    // Short ACKed reply -> length error
    dat[0] = 8'h11; dat[1] = 8'h22;
    run_burst("short", 8'h00, 1'b0, 5'd3, 2, 1'b1);

    // Header-only ACK with nonzero expected length
    run_burst("hdr_only_ack", 8'h00, 1'b0, 5'd1, 0, 1'b1);

    // Reset in the middle of a 5-byte burst
    bdi_aux_in_vld = 1'b1;
    bdi_aux_in = 8'h00;
    aux_ctrl_i2c_native = 1'b0;
    aux_ctrl_exp_len = 5'd5;
    tick();
    bdi_aux_in = 8'hE1;
    tick();
    bdi_aux_in = 8'hE2;
    tick();
    check("mid.data", 32'(reply_data), 32'hE2);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    bdi_aux_in_vld = 1'b0;
    tick();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst.no_done", 32'(reply_done), 32'd0);
    end
    dat[0] = 8'h77; dat[1] = 8'h88;
    run_burst("after_rst", 8'h10, 1'b0, 5'd2, 2, 1'b1);

`ifdef AUX_REPLY_DEC_HDR_CHK_EN
    dat[0] = 8'h01; dat[1] = 8'h02; dat[2] = 8'h03;
    run_burst("hdr_bad", 8'h05, 1'b0, 5'd2, 3, 1'b1);
`endif

    // Random replies, sometimes chained back to back
    for (int k = 0; k < 40; k++) begin
      hdr = 8'($urandom);
`ifdef AUX_REPLY_DEC_HDR_CHK_EN
      if ($urandom_range(0, 3) != 0) hdr[3:0] = 4'h0;
`endif
      n = $urandom_range(0, 20);
      for (int i = 0; i < 32; i++) dat[i] = 8'($urandom);
      run_burst($sformatf("rnd%0d", k), hdr, 1'($urandom),
                ($urandom_range(0, 1) != 0) ? 5'(n) : 5'($urandom_range(0, 20)),
                n, 1'($urandom));
    end
    bdi_aux_in_vld = 1'b0;
    tick();
    tick();
    check("final.done", 32'(reply_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aux_reply_decoder_mb.md
Name: aux_reply_decoder_mb

Overview:
- Parametrised successor to the single-byte AUX reply decoder.
- Parses one AUX reply burst from the bus-driver interface (BDI): a header byte first, then data bytes.
- Latches native or I2C-over-AUX mode and decodes the ACK field.
- Streams data bytes out with a running index, caps the burst at a configurable maximum, and checks the burst length against the expected length at end of reply.
- Sits between the BDI receive path and the AUX controller or transaction engine.

Parameters:
- DATA_W, 8, width of BDI byte and data output; must be >= 8.
- MAX_BYTES, 16, maximum data bytes forwarded per reply; must be >= 1.
- CNT_W, 5, width of byte counters; must satisfy 2^CNT_W > MAX_BYTES.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- bdi_aux_in  in  DATA_W  reply byte from BDI.
- bdi_aux_in_vld  in  1  byte valid; high continuously for the whole burst, low between bursts.
- aux_ctrl_i2c_native  in  1  0 = native, 1 = I2C-over-AUX; sampled only on the header byte.
- aux_ctrl_exp_len  in  CNT_W  expected data-byte count; sampled only on the header byte.
- reply_ack  out  2  decoded ACK field; held until return to IDLE.
- reply_ack_vld  out  1  one-cycle pulse, header decoded.
- reply_dec_i2c_native  out  1  latched mode; held for the reply.
- reply_data  out  DATA_W  data byte.
- reply_data_vld  out  1  reply_data valid, one cycle per forwarded byte.
- reply_data_idx  out  CNT_W  0-based index of the byte on reply_data.
- reply_done  out  1  one-cycle pulse at end of reply.
- reply_byte_cnt  out  CNT_W  bytes forwarded; valid with reply_done.
- reply_len_err  out  1  valid with reply_done.
- reply_ovf  out  1  sticky: bytes dropped beyond MAX_BYTES; cleared on next header.

Behaviour:
- Reset (async, rst_n low): all outputs 0, state IDLE, counters 0. Reset mid-burst aborts the burst with no reply_done.
- All outputs are registered; latency is 1 clk from input byte to output.
- FSM states: IDLE, DATA, DONE.
- IDLE, when bdi_aux_in_vld=1 (header byte):
  - reply_ack <= mode ? bdi_aux_in[7:6] : bdi_aux_in[5:4].
  - reply_ack_vld pulse; latch mode and exp_len; clear count and reply_ovf.
  - Go to DATA.
- DATA, when vld=1:
  - count < MAX_BYTES: reply_data <= byte, reply_data_vld=1, reply_data_idx=count, count++.
  - count == MAX_BYTES: byte dropped, reply_ovf <= 1, count saturates.
- DATA, when vld=0: go to DONE.
- DONE (one cycle):
  - reply_done=1 and reply_byte_cnt=count.
  - reply_len_err = (reply_ack==2'b00) && (count != latched exp_len).
  - reply_ack, reply_dec_i2c_native and reply_ovf stay valid this cycle.
  - Next state IDLE, and reply_ack and reply_dec_i2c_native clear.
  - If vld=1 in DONE, that byte is a new header: process it as in IDLE, go to DATA. The new header overrides the clearing.
- Header-only reply (vld for exactly 1 cycle): reply_done with byte_cnt=0; len_err set iff ACK and exp_len != 0.
- NACK/DEFER replies (ack != 00) still forward any data bytes (e.g. the I2C NACK M byte); len_err is never raised for them.
- reply_data and reply_data_idx go to 0 on any cycle without reply_data_vld.
- reply_ovf asserted implies reply_byte_cnt == MAX_BYTES.

Optional Feature:
- Macro: AUX_REPLY_DEC_HDR_CHK_EN.
- With the macro: header bits [3:0] must be 0.
  - If nonzero: output reply_hdr_err (1 bit) pulses with reply_ack_vld.
  - All data bytes of that reply are suppressed: no reply_data_vld, count stays 0.
  - reply_done still pulses with reply_len_err=0.
- Without the macro: no reply_hdr_err port, and the low nibble is ignored.

Test Plan:
- Native header 0x00, exp_len=4, bytes AA BB CC DD, then vld low -> ack_vld with ack=00, i2c=0; data AA..DD with idx 0..3; done with byte_cnt=4, len_err=0.
- I2C mode, header 0x40, vld for 1 cycle only -> ack=01 (NACK); done with byte_cnt=0, len_err=0.
- Native ACK header 0x00, exp_len=16, 18 data bytes 0x01..0x12 -> bytes 0x01..0x10 forwarded, 0x11 and 0x12 dropped; reply_ovf=1; byte_cnt=16.
- Native header 0x20 (DEFER) with exp_len=2 -> ack=10, no data, len_err=0. Then a new header arrives in the DONE cycle -> ack_vld next clk with no IDLE gap.
- Native ACK, exp_len=3, 2 bytes -> done with byte_cnt=2, len_err=1.
- rst_n asserted after byte 2 of 5 -> all outputs 0 immediately, no reply_done; the next burst decodes normally. With AUX_REPLY_DEC_HDR_CHK_EN, header 0x05 -> reply_hdr_err pulse and no data.
